// File: rtl/cmb_result_monitor.sv
// Capture stage behind the cmb benchmark: per-output saturating hit counters
// plus a small FIFO of result-change events {res, vec} drained by a consumer.

module cmb_hit_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end
endmodule

module cmb_result_monitor #(
    parameter int VEC_W      = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [VEC_W-1:0]            in_vec,
    input  logic [3:0]                  in_res,
    input  logic                        clr,
    input  logic [1:0]                  cnt_sel,
    output logic [CNT_W-1:0]            cnt_val,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [VEC_W+3:0]            ev_data,
    output logic [$clog2(FIFO_DEPTH):0] ev_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [3:0]       res;
        logic [VEC_W-1:0] vec;
    } ev_t;

    state_t             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic               accept, push, pop, full;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    ev_t                mem [FIFO_DEPTH];
    logic [3:0][CNT_W-1:0] cnt;

    // Ready is gated by reset so nothing is taken while the block is held.
    assign full     = (ev_count == DEPTH_C);
    assign in_ready = rst_n && !clr && !full;
    assign accept   = in_valid && in_ready;
    assign ev_valid = (ev_count != '0);
    assign pop      = ev_valid && ev_ready;

    // ---------------- change-detect FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            prev_d  = '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    // First sample after reset/clear only establishes the baseline.
                    prev_d  = in_res;
                    state_d = RUN;
                end
                RUN: begin
                    if (in_res != prev_q) begin
                        push   = 1'b1;
                        prev_d = in_res;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- hit counters, one per result bit ----------------
    for (genvar k = 0; k < 4; k++) begin : g_cnt
        cmb_hit_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (accept && in_res[k]),
            .cnt   (cnt[k])
        );
    end

    assign cnt_val = cnt[cnt_sel];

    // ---------------- event FIFO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   ev_count <= ev_count + (PW+1)'(1);
                2'b01:   ev_count <= ev_count - (PW+1)'(1);
                default: ev_count <= ev_count;
            endcase
        end
    end

    // Storage needs no reset: ev_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{res: in_res, vec: in_vec};
    end

    assign ev_data = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_cmb_result_monitor.sv
// Directed bench for cmb_result_monitor with an event scoreboard and a
// reference model of counters and baseline tracking.

module tb_cmb_result_monitor;
    localparam int VEC_W = 16;
    localparam int CNT_W = 4;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid, in_ready, clr, ev_valid, ev_ready;
    logic [VEC_W-1:0]   in_vec;
    logic [3:0]         in_res;
    logic [1:0]         cnt_sel;
    logic [CNT_W-1:0]   cnt_val;
    logic [VEC_W+3:0]   ev_data;
    logic [$clog2(DEPTH):0] ev_count;

    int n_chk = 0;
    int n_bad = 0;
    logic [VEC_W+3:0] sb[$];
    logic       m_run;
    logic [3:0] m_prev;
    int         m_cnt[4];
    int         pops = 0;
    int         max_cnt = 0;
    bit         track = 1'b0;

    cmb_result_monitor #(.VEC_W(VEC_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .in_res   (in_res),
        .clr      (clr),
        .cnt_sel  (cnt_sel),
        .cnt_val  (cnt_val),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .ev_count (ev_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_prev = '0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    task automatic model_accept(input logic [VEC_W-1:0] v, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[k] && m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
        if (!m_run) begin
            m_run  = 1'b1;
            m_prev = r;
        end else if (r != m_prev) begin
            sb.push_back({r, v});
            m_prev = r;
        end
    endtask

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic send(input logic [VEC_W-1:0] v, input logic [3:0] r);
        int t = 0;
        in_vec   = v;
        in_res   = r;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (in_ready) model_accept(v, r);
        else chk("send_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at a falling edge; reads all four counters, ends at the next falling edge.
    task automatic cnt_chk(input string tag);
        for (int k = 0; k < 4; k++) begin
            cnt_sel = 2'(k);
            #1;
            chk(tag, cnt_val, m_cnt[k]);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        ev_ready = 1'b1;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
        ev_ready = 1'b0;
        #1;
        chk("drain_empty", {31'b0, ev_valid}, 32'd0);
        @(negedge clk);
    endtask

    // Consumer side: every pop must match the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && ev_valid && ev_ready) begin
            if (sb.size() == 0) chk("ev_unexpected", {31'b0, ev_valid}, 32'd0);
            else begin
                chk("ev_data", ev_data, sb.pop_front());
                pops++;
            end
        end
        if (track && int'(ev_count) > max_cnt) max_cnt = int'(ev_count);
    end

    initial begin
        int i;
        int p0;
        in_valid = 1'b0; in_vec = '0; in_res = '0;
        clr = 1'b0; cnt_sel = '0; ev_ready = 1'b0;
        model_reset();

        // reset state
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_ev_valid", {31'b0, ev_valid}, 32'd0);
        chk("rst_ev_count", ev_count, 32'd0);
        chk("rst_ev_data",  ev_data,  32'd0);
        chk("rst_cnt",      cnt_val,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: baseline sample only
        send(16'hFFFF, 4'b1000);
        chk("t1_no_event", {31'b0, ev_valid}, 32'd0);
        cnt_chk("t1_cnt");

        // 2: change detection
        send(16'h0001, 4'b1000);
        send(16'h1234, 4'b0110);
        #1;
        chk("t2_ev_valid", {31'b0, ev_valid}, 32'd1);
        chk("t2_ev_data", ev_data, {4'b0110, 16'h1234});
        send(16'h5555, 4'b0110);
        chk("t2_ev_count", ev_count, 32'd1);
        cnt_chk("t2_cnt");
        drain();

        // 3: fill FIFO with back-pressure, then single pop
        i = 0;
        while (sb.size() < DEPTH && i < 16) begin
            send(16'h3000 + 16'(i), {3'b0, i[0]});
            i++;
        end
        chk("t3_full_count", ev_count, 32'd4);
        chk("t3_full_ready", {31'b0, in_ready}, 32'd0);
        ev_ready = 1'b1;
        #1;
        chk("t3_no_passthru", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        ev_ready = 1'b0;
        #1;
        chk("t3_ready_after_pop", {31'b0, in_ready}, 32'd1);
        chk("t3_count_after_pop", ev_count, 32'd3);
        @(negedge clk);
        drain();

        // 4: continuous streaming with wrap-around
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        ev_ready = 1'b1;
        track = 1'b1;
        max_cnt = 0;
        p0 = pops;
        for (int k = 0; k < 10; k++) send(16'hA000 + 16'(k), {3'b0, k[0]});
        drain();
        track = 1'b0;
        chk("t4_events", pops - p0, 32'd9);
        chk("t4_max_count", {31'b0, max_cnt <= 2}, 32'd1);

        // 5: clr priority with events queued
        send(16'hB001, 4'b0000);
        send(16'hB002, 4'b0001);
        clr = 1'b1; in_valid = 1'b1; in_res = 4'b1111; in_vec = 16'hB003;
        #1;
        chk("t5_clr_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        model_reset();
        cnt_chk("t5_cnt_cleared");
        chk("t5_queue_kept", ev_count, 32'd2);
        send(16'hB004, 4'b1111);
        chk("t5_baseline_only", ev_count, 32'd2);
        drain();

        // 6: saturation, then async reset with events queued
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) send(16'hC000 + 16'(k), 4'b0001);
        cnt_sel = 2'd0;
        #1;
        chk("t6_saturate", cnt_val, 32'd15);
        chk("t6_no_events", ev_count, 32'd0);
        @(negedge clk);
        send(16'hD001, 4'b0010);
        send(16'hD002, 4'b0001);
        chk("t6_queued", ev_count, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ev_valid", {31'b0, ev_valid}, 32'd0);
        chk("t6_rst_ev_count", ev_count, 32'd0);
        chk("t6_rst_in_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cnt_sel = 2'(k);
            #1;
            chk("t6_rst_cnt", cnt_val, 32'd0);
        end
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rst_valid", {31'b0, ev_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
